// File: rtl/wm_alpha_mult.sv
// Sequential shift-add multiplier feeding the /1e6 watermark quantiser; clamps prod1 to PROD_MAX.
// Optional WM_MULT_EARLY_EXIT_EN: leave MUL as soon as the remaining pixel bits are all zero.
module wm_alpha_mult #(
    parameter int unsigned A_W      = 8,
    parameter int unsigned B_W      = 14,
    parameter int unsigned P_W      = 22,
    parameter int unsigned PROD_MAX = 3999999
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] pix_in,
    input  logic [B_W-1:0] alpha_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] prod1,
    output logic           sat_flag,
    output logic           busy
);

    localparam int unsigned ACC_W = P_W + 1;
    localparam int unsigned CNT_W = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [ACC_W-1:0] PROD_MAX_ACC = ACC_W'(PROD_MAX);
    localparam logic [P_W-1:0]   PROD_MAX_OUT = P_W'(PROD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(A_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [A_W-1:0]   a_sh;
    logic [ACC_W-1:0] b_sh;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] acc_sum;
    logic [A_W-1:0]   a_next;
    logic             acc_over;
    logic             last_step;

    // One shift-add step; acc is one bit wider than prod1 so the raw product cannot wrap.
    always_comb begin
        acc_sum = acc;
        if (a_sh[0]) begin
            acc_sum = acc + b_sh;
        end
        a_next   = a_sh >> 1;
        acc_over = (acc_sum > PROD_MAX_ACC);
`ifdef WM_MULT_EARLY_EXIT_EN
        last_step = (cnt == CNT_LAST) || (a_next == '0);
`else
        last_step = (cnt == CNT_LAST);
`endif
    end

    // Accept only in IDLE, and never while reset is held.
    assign in_ready = !rst && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            prod1     <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh  <= pix_in;
                        b_sh  <= ACC_W'(alpha_in);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc_sum;
                    a_sh <= a_next;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt + CNT_W'(1);
                    // Result registers change only here, so they hold through DONE and IDLE.
                    if (last_step) begin
                        prod1     <= acc_over ? PROD_MAX_OUT : P_W'(acc_sum);
                        sat_flag  <= acc_over;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
